// File: rtl/ariane_pkg.sv
// Shared execute-stage types: exception record, writeback entry and the
// default per-channel result FIFO depth used by wb_port_arbiter.
package ariane_pkg;

   localparam int unsigned TRANS_ID_BITS = 3;
   localparam int unsigned WB_FIFO_DEPTH = 2;

   typedef struct packed {
      logic [63:0] cause;
      logic [63:0] tval;
      logic        valid;
   } exception_t;

   typedef struct packed {
      logic [63:0]              result;
      logic [TRANS_ID_BITS-1:0] trans_id;
      exception_t               exception;
   } wb_entry_t;

   // Channels served by one write port under the static c mod ports mapping
   function automatic int unsigned chans_per_port(int unsigned nr_ch, int unsigned nr_ports);
      return (nr_ch + nr_ports - 1) / nr_ports;
   endfunction

endpackage

// File: rtl/wb_chan_fifo.sv
// Per-channel result FIFO for the writeback arbiter. Read/write pointers carry
// one extra wrap bit so full and empty are distinguished by the MSB.
module wb_chan_fifo import ariane_pkg::*; #(
   parameter int unsigned Depth = WB_FIFO_DEPTH
) (
   input  logic      clk_i,
   input  logic      rst_ni,
   input  logic      flush_i,
   input  logic      push_i,
   input  wb_entry_t data_i,
   input  logic      pop_i,
   output wb_entry_t data_o,
   output logic      full_o,
   output logic      empty_o
);

   localparam int unsigned AW = $clog2(Depth);
   localparam logic [AW:0] PtrOne = (AW+1)'(1);

   logic [AW:0] wr_ptr_q, rd_ptr_q;
   wb_entry_t   mem_q [Depth];
   logic        do_push, do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_push = push_i && !full_o && !flush_i;
   assign do_pop  = pop_i && !empty_o && !flush_i;
   assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

   // Occupancy pointers: flush and reset both empty the FIFO
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      end
   end

   // Storage array: contents are only meaningful between the pointers
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback arbiter: NrChannels buffered result channels merged onto NrWbPorts
// scoreboard write ports, channel c statically mapped to port c mod NrWbPorts,
// round-robin within each port.
// Optional feature: define WB_ARB_BYPASS_EN to present a result arriving at an
// empty, winning channel on the write port in the same cycle.
module wb_port_arbiter import ariane_pkg::*; #(
   parameter int unsigned NrChannels = 4,
   parameter int unsigned NrWbPorts  = 2,
   parameter int unsigned FifoDepth  = WB_FIFO_DEPTH
) (
   input  logic                                      clk_i,
   input  logic                                      rst_ni,
   input  logic                                      flush_i,
   input  logic [NrChannels-1:0]                     ch_valid_i,
   output logic [NrChannels-1:0]                     ch_ready_o,
   input  logic [NrChannels-1:0][63:0]               ch_result_i,
   input  logic [NrChannels-1:0][TRANS_ID_BITS-1:0]  ch_trans_id_i,
   input  exception_t [NrChannels-1:0]               ch_exception_i,
   output logic [NrWbPorts-1:0]                      wb_valid_o,
   input  logic [NrWbPorts-1:0]                      wb_ready_i,
   output logic [NrWbPorts-1:0][63:0]                wb_result_o,
   output logic [NrWbPorts-1:0][TRANS_ID_BITS-1:0]   wb_trans_id_o,
   output exception_t [NrWbPorts-1:0]                wb_exception_o
);

   localparam int unsigned PerPort = chans_per_port(NrChannels, NrWbPorts);
   localparam int unsigned RrW     = (PerPort > 1) ? $clog2(PerPort) : 1;
   localparam logic [RrW-1:0] RrLast = RrW'(PerPort - 1);
   localparam logic [RrW-1:0] RrOne  = RrW'(1);

   wb_entry_t               in_entry [NrChannels];
   wb_entry_t               head     [NrChannels];
   wb_entry_t               src      [NrChannels];
   wb_entry_t               out_entry[NrWbPorts];
   logic [NrChannels-1:0]   full, empty, push, pop, cand, sel;
   logic [NrWbPorts-1:0]    port_any, hs;
   logic [RrW-1:0]          rr_q     [NrWbPorts];
   logic [RrW-1:0]          lock_k_q [NrWbPorts];
   logic [RrW-1:0]          gnt_k    [NrWbPorts];
   logic [NrWbPorts-1:0]    lock_q;

   assign ch_ready_o = ~full;

   // Pack the per-channel input fields into FIFO words
   always_comb begin
      for (int unsigned c = 0; c < NrChannels; c++) begin
         in_entry[c].result    = ch_result_i[c];
         in_entry[c].trans_id  = ch_trans_id_i[c];
         in_entry[c].exception = ch_exception_i[c];
      end
   end

   for (genvar c = 0; c < NrChannels; c++) begin : g_chan
      wb_chan_fifo #(
         .Depth (FifoDepth)
      ) i_fifo (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .flush_i (flush_i),
         .push_i  (push[c]),
         .data_i  (in_entry[c]),
         .pop_i   (pop[c]),
         .data_o  (head[c]),
         .full_o  (full[c]),
         .empty_o (empty[c])
      );
   end

   // Arbitration candidates and the word each channel would present
   always_comb begin
      cand = '0;
      for (int unsigned c = 0; c < NrChannels; c++) begin
`ifdef WB_ARB_BYPASS_EN
         cand[c] = !empty[c] || (ch_valid_i[c] && !flush_i);
         src[c]  = empty[c] ? in_entry[c] : head[c];
`else
         cand[c] = !empty[c];
         src[c]  = head[c];
`endif
      end
   end

   // Round-robin search per port; a stalled grant is locked so the output
   // cannot change while valid is high and ready is low.
   always_comb begin
      wb_valid_o = '0;
      port_any   = '0;
      for (int unsigned p = 0; p < NrWbPorts; p++) begin
         gnt_k[p] = '0;
         for (int unsigned off = 0; off < PerPort; off++) begin
            int unsigned k, ch;
            k  = (32'(rr_q[p]) + off) % PerPort;
            ch = p + k * NrWbPorts;
            if (!port_any[p] && (ch < NrChannels) && cand[ch]) begin
               port_any[p] = 1'b1;
               gnt_k[p]    = RrW'(k);
            end
         end
         if (lock_q[p]) gnt_k[p] = lock_k_q[p];
         wb_valid_o[p] = port_any[p] && !flush_i;
      end
   end

   // Channel select, handshake, and FIFO push/pop strobes
   always_comb begin
      sel  = '0;
      push = '0;
      pop  = '0;
      hs   = wb_valid_o & wb_ready_i;
      for (int unsigned c = 0; c < NrChannels; c++) begin
         int unsigned p, k;
         logic        taken;
         p      = c % NrWbPorts;
         k      = c / NrWbPorts;
         sel[c] = wb_valid_o[p] && (gnt_k[p] == RrW'(k));
         taken  = sel[c] && hs[p];
         pop[c] = taken && !empty[c];
         // A bypassed result consumed by the scoreboard is never stored
         push[c] = ch_valid_i[c] && !full[c] && !flush_i && !(taken && empty[c]);
      end
   end

   // Output mux: head of the granted channel, zero when the port is idle
   always_comb begin
      for (int unsigned p = 0; p < NrWbPorts; p++) begin
         out_entry[p] = '0;
         for (int unsigned k = 0; k < PerPort; k++) begin
            int unsigned ch;
            ch = p + k * NrWbPorts;
            if ((ch < NrChannels) && sel[ch]) out_entry[p] = src[ch];
         end
         wb_result_o[p]    = out_entry[p].result;
         wb_trans_id_o[p]  = out_entry[p].trans_id;
         wb_exception_o[p] = out_entry[p].exception;
      end
   end

   // Round-robin pointers and stall locks per port
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lock_q <= '0;
         for (int unsigned p = 0; p < NrWbPorts; p++) begin
            rr_q[p]     <= '0;
            lock_k_q[p] <= '0;
         end
      end else if (flush_i) begin
         lock_q <= '0;
         for (int unsigned p = 0; p < NrWbPorts; p++) begin
            rr_q[p]     <= '0;
            lock_k_q[p] <= '0;
         end
      end else begin
         for (int unsigned p = 0; p < NrWbPorts; p++) begin
            if (hs[p]) begin
               rr_q[p]   <= (gnt_k[p] == RrLast) ? '0 : gnt_k[p] + RrOne;
               lock_q[p] <= 1'b0;
            end else if (wb_valid_o[p]) begin
               lock_q[p]   <= 1'b1;
               lock_k_q[p] <= gnt_k[p];
            end
         end
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (4 channels, 2 ports, depth 2).
// Expectations adapt to WB_ARB_BYPASS_EN when that macro is defined.
module tb_wb_port_arbiter;
   import ariane_pkg::*;

`ifdef WB_ARB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic                              clk = 1'b0;
   logic                              rst_n;
   logic                              flush;
   logic [3:0]                        ch_valid, ch_ready;
   logic [3:0][63:0]                  ch_result;
   logic [3:0][TRANS_ID_BITS-1:0]     ch_trans_id;
   exception_t [3:0]                  ch_exception;
   logic [1:0]                        wb_valid, wb_ready;
   logic [1:0][63:0]                  wb_result;
   logic [1:0][TRANS_ID_BITS-1:0]     wb_trans_id;
   exception_t [1:0]                  wb_exception;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   wb_port_arbiter #(
      .NrChannels (4),
      .NrWbPorts  (2),
      .FifoDepth  (2)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .flush_i        (flush),
      .ch_valid_i     (ch_valid),
      .ch_ready_o     (ch_ready),
      .ch_result_i    (ch_result),
      .ch_trans_id_i  (ch_trans_id),
      .ch_exception_i (ch_exception),
      .wb_valid_o     (wb_valid),
      .wb_ready_i     (wb_ready),
      .wb_result_o    (wb_result),
      .wb_trans_id_o  (wb_trans_id),
      .wb_exception_o (wb_exception)
   );

   typedef struct {
      logic        flush;
      logic [3:0]  vld;
      logic [1:0]  rdy;
      logic [3:0]  exp_chrdy;
      logic [1:0]  exp_wbv;
      logic [63:0] exp_r0;
      logic [63:0] exp_r1;
   } vec_t;

   vec_t vt [13];

   function automatic logic [63:0] dat(int unsigned c, int unsigned i);
      return 64'h1000 * 64'(c + 1) + 64'(i);
   endfunction

   function automatic vec_t mk(logic fl, logic [3:0] v, logic [1:0] r, logic [3:0] cr,
                               logic [1:0] wv, logic [63:0] e0, logic [63:0] e1);
      vec_t x;
      x.flush = fl; x.vld = v; x.rdy = r; x.exp_chrdy = cr;
      x.exp_wbv = wv; x.exp_r0 = e0; x.exp_r1 = e1;
      return x;
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      ch_valid = '0;
      for (int c = 0; c < 4; c++) begin
         ch_result[c]   = '0;
         ch_trans_id[c] = '0;
      end
   endtask

   task automatic drive_ch(int unsigned c, logic v, logic [63:0] r, logic [TRANS_ID_BITS-1:0] id);
      ch_valid[c]    = v;
      ch_result[c]   = r;
      ch_trans_id[c] = id;
   endtask

   task automatic flush_cycle();
      @(negedge clk);
      idle_inputs();
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] got [$];
      logic [63:0] exp_rr [6];
      int unsigned n0, n2;
      logic        a0, a2;

      rst_n = 1'b0;
      flush = 1'b0;
      wb_ready = '0;
      for (int c = 0; c < 4; c++) ch_exception[c] = '0;
      idle_inputs();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // ---- reset release and first result latency ----
      #1;
      check("reset ch_ready", 64'(ch_ready), 64'hF);
      check("reset wb_valid", 64'(wb_valid), 64'h0);
      check("reset wb_result0", wb_result[0], 64'h0);
      @(negedge clk);
      wb_ready = 2'b11;
      drive_ch(0, 1'b1, 64'hDEAD, 3'd3);
      #1;
      check("first same-cycle valid", 64'(wb_valid), BYP ? 64'h1 : 64'h0);
      check("first same-cycle result", wb_result[0], BYP ? 64'hDEAD : 64'h0);
      @(negedge clk);
      idle_inputs();
      #1;
      check("first next-cycle valid", 64'(wb_valid), BYP ? 64'h0 : 64'h1);
      check("first next-cycle result", wb_result[0], BYP ? 64'h0 : 64'hDEAD);
      check("first next-cycle id", 64'(wb_trans_id[0]), BYP ? 64'h0 : 64'h3);
      check("first exception", 64'(wb_exception[0].valid), 64'h0);

      // ---- table: backpressure/full/drain on port1, flush, parallel ports ----
      vt[0]  = mk(1'b0, 4'b0000, 2'b11, 4'b1111, 2'b00, '0, '0);
      vt[1]  = mk(1'b0, 4'b0010, 2'b00, 4'b1111, BYP ? 2'b10 : 2'b00, '0, BYP ? dat(1, 1) : '0);
      vt[2]  = mk(1'b0, 4'b0010, 2'b00, 4'b1111, 2'b10, '0, dat(1, 1));
      vt[3]  = mk(1'b0, 4'b0000, 2'b00, 4'b1101, 2'b10, '0, dat(1, 1));
      vt[4]  = mk(1'b0, 4'b1000, 2'b00, 4'b1101, 2'b10, '0, dat(1, 1));
      vt[5]  = mk(1'b0, 4'b0000, 2'b10, 4'b1101, 2'b10, '0, dat(1, 1));
      vt[6]  = mk(1'b0, 4'b0000, 2'b10, 4'b1111, 2'b10, '0, dat(3, 4));
      vt[7]  = mk(1'b0, 4'b0000, 2'b10, 4'b1111, 2'b10, '0, dat(1, 2));
      vt[8]  = mk(1'b1, 4'b0101, 2'b11, 4'b1111, 2'b00, '0, '0);
      vt[9]  = mk(1'b0, 4'b0000, 2'b11, 4'b1111, 2'b00, '0, '0);
      vt[10] = mk(1'b0, 4'b0011, 2'b11, 4'b1111, BYP ? 2'b11 : 2'b00,
                  BYP ? dat(0, 10) : '0, BYP ? dat(1, 10) : '0);
      vt[11] = mk(1'b0, 4'b0000, 2'b11, 4'b1111, BYP ? 2'b00 : 2'b11,
                  BYP ? '0 : dat(0, 10), BYP ? '0 : dat(1, 10));
      vt[12] = mk(1'b0, 4'b0000, 2'b11, 4'b1111, 2'b00, '0, '0);

      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         flush = vt[i].flush;
         wb_ready = vt[i].rdy;
         for (int c = 0; c < 4; c++)
            drive_ch(c, vt[i].vld[c], dat(c, i), TRANS_ID_BITS'(c));
         #1;
         check($sformatf("row%0d ch_ready", i), 64'(ch_ready), 64'(vt[i].exp_chrdy));
         check($sformatf("row%0d wb_valid", i), 64'(wb_valid), 64'(vt[i].exp_wbv));
         check($sformatf("row%0d wb_result0", i), wb_result[0], vt[i].exp_r0);
         check($sformatf("row%0d wb_result1", i), wb_result[1], vt[i].exp_r1);
      end
      @(negedge clk);
      idle_inputs();
      flush = 1'b0;

      // ---- round-robin between ch0 and ch2 on port0 ----
      flush_cycle();
      exp_rr = '{dat(0, 0), dat(2, 0), dat(0, 1), dat(2, 1), dat(0, 2), dat(2, 2)};
      n0 = 0;
      n2 = 0;
      for (int cyc = 0; cyc < 30 && got.size() < 6; cyc++) begin
         if (cyc != 0) @(negedge clk);
         wb_ready = 2'b01;
         drive_ch(0, n0 < 3, dat(0, n0), 3'd0);
         drive_ch(2, n2 < 3, dat(2, n2), 3'd2);
         #1;
         a0 = ch_valid[0] & ch_ready[0];
         a2 = ch_valid[2] & ch_ready[2];
         if (wb_valid[0] && wb_ready[0]) got.push_back(wb_result[0]);
         @(posedge clk);
         n0 += 32'(a0);
         n2 += 32'(a2);
      end
      @(negedge clk);
      idle_inputs();
      check("rr count", 64'(got.size()), 64'd6);
      for (int k = 0; k < 6; k++)
         check($sformatf("rr order %0d", k), (k < got.size()) ? got[k] : '1, exp_rr[k]);

      // ---- flush discards buffered and incoming results ----
      wb_ready = 2'b00;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         drive_ch(0, 1'b1, dat(0, 20 + i), 3'd0);
         drive_ch(3, 1'b1, dat(3, 20 + i), 3'd3);
      end
      @(negedge clk);
      idle_inputs();
      drive_ch(0, 1'b1, dat(0, 30), 3'd0);
      flush = 1'b1;
      wb_ready = 2'b11;
      #1;
      check("flush cycle wb_valid", 64'(wb_valid), 64'h0);
      check("flush cycle ch_ready", 64'(ch_ready), 64'h6);
      @(negedge clk);
      flush = 1'b0;
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("post-flush %0d wb_valid", i), 64'(wb_valid), 64'h0);
         check($sformatf("post-flush %0d ch_ready", i), 64'(ch_ready), 64'hF);
         @(negedge clk);
      end

      // ---- asynchronous reset while entries are buffered ----
      wb_ready = 2'b00;
      drive_ch(0, 1'b1, dat(0, 40), 3'd0);
      drive_ch(1, 1'b1, dat(1, 40), 3'd1);
      @(negedge clk);
      idle_inputs();
      #1;
      check("pre-reset wb_valid", 64'(wb_valid), 64'h3);
      #2;
      rst_n = 1'b0;
      #1;
      check("async reset wb_valid", 64'(wb_valid), 64'h0);
      check("async reset wb_result0", wb_result[0], 64'h0);
      check("async reset ch_ready", 64'(ch_ready), 64'hF);
      @(negedge clk);
      rst_n = 1'b1;
      wb_ready = 2'b11;
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("post-reset %0d wb_valid", i), 64'(wb_valid), 64'h0);
         @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
